// File: rtl/seven_segment_scan_driver.sv
// Purpose: round-robin scan of DIGITS common-anode hex digits with PWM dimming, leading-zero blanking and anti-ghost gap.
// Latency: outputs are registered one cycle behind slot counter, digit index and shadow state.
// Backpressure: none; load is accepted on any cycle and the scan free-runs.
module seven_segment_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000,
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dots,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int SLICE = PRESCALE / 16;
    localparam int SUB_W = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SLICE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Slot counter is kept as {phase, sub} so phase needs no divider.
    logic [SUB_W-1:0]      sub;
    logic [3:0]            phase;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   value_sh;
    logic [DIGITS-1:0]     dots_sh;
    logic [DIGITS-1:0]     en_sh;
    logic [DIGITS-1:0]     blank_sh;
    logic [DIGITS-1:0]     blank_nxt;
    logic                  zero_above;

    logic                  slot_end;
    logic                  cnt_zero;
    logic                  lit;
    logic [3:0]            nib;
    logic [6:0]            seg_dec;
    logic [DIGITS-1:0]     an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    logic [DIGITS-1:0]     an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic                  fd_q;

    assign slot_end = (sub == SUB_LAST) && (phase == 4'd15);
    assign cnt_zero = (sub == '0) && (phase == 4'd0);

    // Blank mask is derived from the incoming value so it lands with the shadow.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (value[4*i +: 4] == 4'h0);
            blank_nxt[i] = lz_blank && zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub      <= '0;
            phase    <= 4'd0;
            idx      <= '0;
            value_sh <= '0;
            dots_sh  <= '0;
            en_sh    <= '0;
            blank_sh <= '0;
        end else begin
            if (sub == SUB_LAST) begin
                sub   <= '0;
                phase <= phase + 4'd1;
            end else begin
                sub <= sub + SUB_W'(1);
            end
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            if (load) begin
                value_sh <= value;
                dots_sh  <= dots;
                en_sh    <= digit_en;
                blank_sh <= blank_nxt;
            end
        end
    end

    assign nib = value_sh[{idx, 2'b00} +: 4];

    always_comb begin
        seg_dec = 7'h7F;
        case (nib)
            4'h0: seg_dec = 7'h01;
            4'h1: seg_dec = 7'h4F;
            4'h2: seg_dec = 7'h12;
            4'h3: seg_dec = 7'h06;
            4'h4: seg_dec = 7'h4C;
            4'h5: seg_dec = 7'h24;
            4'h6: seg_dec = 7'h20;
            4'h7: seg_dec = 7'h0F;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h04;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h60;
            4'hC: seg_dec = 7'h31;
            4'hD: seg_dec = 7'h42;
            4'hE: seg_dec = 7'h30;
            4'hF: seg_dec = 7'h38;
            default: seg_dec = 7'h7F;
        endcase
    end

    // Counter value 0 is the anti-ghost gap between digits.
    assign lit = en_sh[idx] && !cnt_zero && (phase <= brightness);

    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (lit) begin
            an_nxt  = ~(DIGITS'(1) << idx);
            seg_nxt = blank_sh[idx] ? 7'h7F : seg_dec;
            dp_nxt  = ~dots_sh[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
            fd_q  <= slot_end && (idx == IDX_LAST);
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for the scan driver with DIGITS=4, PRESCALE=16: per-cycle expected outputs are queued
// by the stimulus process and popped by a negedge monitor.
module tb_seven_segment_scan_driver;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 16;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  digit_en;
    logic        load;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seven_segment_scan_driver #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dots       (dots),
        .digit_en   (digit_en),
        .load       (load),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   fd_count = 0;

    logic [6:0] dec [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference state: time since reset plus the shadowed inputs.
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] sh_val = '0;
    logic [3:0]  sh_dots = '0;
    logic [3:0]  sh_en = '0;
    logic        sh_lz = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            nvec++;
            if (frame_done === 1'b1) fd_count++;
            if ({an, seg, dp, frame_done} !== e) begin
                nerr++;
                $display("FAIL outputs t=%0t: an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    end

    task automatic step();
        exp_t e;
        int   hi;
        logic [3:0] n;
        logic blank, lit;
        if (rst) begin
            e = {4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
            hi = 0;
            for (int i = 0; i < 4; i++)
                if (sh_val[i*4 +: 4] != 4'h0) hi = i;
            n     = sh_val[m_idx*4 +: 4];
            blank = sh_lz && (m_idx > hi);
            lit   = sh_en[m_idx] && (m_cnt != 0) && ((m_cnt / (PRESCALE/16)) <= int'(brightness));
            e.fd  = (m_cnt == PRESCALE-1) && (m_idx == DIGITS-1);
            if (lit) begin
                e.an  = 4'hF & ~(4'b0001 << m_idx);
                e.seg = blank ? 7'h7F : dec[n];
                e.dp  = ~sh_dots[m_idx];
            end else begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end
        end
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_idx = 0;
            sh_val = '0; sh_dots = '0; sh_en = '0; sh_lz = 1'b0;
        end else begin
            if (load) begin
                sh_val = value; sh_dots = dots; sh_en = digit_en; sh_lz = lz_blank;
            end
            if (m_cnt == PRESCALE-1) begin
                m_cnt = 0;
                m_idx = (m_idx == DIGITS-1) ? 0 : m_idx + 1;
            end else begin
                m_cnt++;
            end
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en,
                           input logic lz);
        value = v; dots = d; digit_en = en; lz_blank = lz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dots = '0; digit_en = '0;
        lz_blank = 1'b0; brightness = 4'd15;

        // Reset held, then dark scanning with frame pulses every 64 cycles.
        run(3);
        rst = 1'b0;
        @(negedge clk); #1;
        fd_count = 0;
        run(200);
        @(negedge clk); #1;
        nvec++;
        if (fd_count != 3) begin
            nerr++;
            $display("FAIL frame_count: got %0d pulses, want 3", fd_count);
        end

        // Full brightness display of 12AF with a dot on digit 2.
        do_load(16'h12AF, 4'b0100, 4'hF, 1'b0);
        run(128);

        // Reduced duty.
        brightness = 4'd3;
        run(64);
        brightness = 4'd15;

        // Leading-zero blanking, then the all-zero value.
        do_load(16'h0050, 4'b1000, 4'hF, 1'b1);
        run(64);
        do_load(16'h0000, 4'b0000, 4'hF, 1'b1);
        run(64);

        // Disabled digits keep the slot timing.
        do_load(16'h12AF, 4'b0001, 4'b0101, 1'b0);
        run(64);

        // Mid-slot load at counter 7.
        do_load(16'hC0DE, 4'hF, 4'hF, 1'b0);
        for (int k = 0; k < 64 && m_cnt != 7; k++) step();
        do_load(16'h3456, 4'h0, 4'hF, 1'b0);
        run(20);

        // Reset colliding with a load during slot 2.
        for (int k = 0; k < 128 && !(m_idx == 2 && m_cnt == 5); k++) step();
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; digit_en = 4'hF; dots = 4'hF;
        step();
        rst = 1'b0; load = 1'b0;
        run(80);

        @(negedge clk); #1;
        nvec++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
